// File: rtl/pong_if.sv
// Pong game-state bus: per-frame controls in, renderer positions out.
// master drives the controls, slave is the game controller.
interface pong_if;
    logic       frame_tick;
    logic       btn_left_up;
    logic       btn_left_down;
    logic       btn_right_up;
    logic       btn_right_down;
    logic       serve;
    logic [8:0] pad_left;
    logic [8:0] pad_right;
    logic [9:0] ball_x;
    logic [8:0] ball_y;
    logic [3:0] score_left;
    logic [3:0] score_right;
    logic [1:0] phase;

    modport master (
        output frame_tick, btn_left_up, btn_left_down,
        output btn_right_up, btn_right_down, serve,
        input  pad_left, pad_right, ball_x, ball_y,
        input  score_left, score_right, phase
    );

    modport slave (
        input  frame_tick, btn_left_up, btn_left_down,
        input  btn_right_up, btn_right_down, serve,
        output pad_left, pad_right, ball_x, ball_y,
        output score_left, score_right, phase
    );
endinterface

// File: rtl/pong_game_controller.sv
// Per-frame Pong game-state sequencer: paddles, ball, scores, phase.
// All state advances only on the clk_vga edge that carries frame_tick.
module pong_game_controller #(
    parameter int SCREEN_WIDTH  = 640,
    parameter int SCREEN_HEIGHT = 480,
    parameter int PAD_DISTANCE  = 16,
    parameter int PAD_WIDTH     = 8,
    parameter int PAD_HEIGHT    = 64,
    parameter int BALL_SIZE     = 8,
    parameter int PAD_SPEED     = 4,
    parameter int BALL_SPEED    = 2,
    parameter int PAUSE_FRAMES  = 60,
    parameter int WIN_SCORE     = 9
) (
    input logic   clk_vga,
    input logic   rst,
    pong_if.slave bus
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PLAY  = 2'd1,
        POINT = 2'd2,
        OVER  = 2'd3
    } phase_e;

    localparam int PW = $clog2(PAUSE_FRAMES + 1);

    localparam logic signed [11:0] PAD_MIN  = 12'(PAD_HEIGHT / 2);
    localparam logic signed [11:0] PAD_MAX  =
        12'(SCREEN_HEIGHT - 1 - PAD_HEIGHT / 2);
    localparam logic signed [11:0] PAD_STEP = 12'(PAD_SPEED);
    localparam logic signed [11:0] BSPD     = 12'(BALL_SPEED);
    localparam logic signed [11:0] Y_MIN    = 12'(BALL_SIZE / 2);
    localparam logic signed [11:0] Y_MAX    =
        12'(SCREEN_HEIGHT - 1 - BALL_SIZE / 2);
    localparam logic signed [11:0] XL       =
        12'(PAD_DISTANCE + PAD_WIDTH + BALL_SIZE / 2);
    localparam logic signed [11:0] XR       =
        12'(SCREEN_WIDTH - PAD_DISTANCE - PAD_WIDTH - BALL_SIZE / 2);
    localparam logic signed [11:0] MISS_L   = 12'(BALL_SIZE / 2);
    localparam logic signed [11:0] MISS_R   =
        12'(SCREEN_WIDTH - 1 - BALL_SIZE / 2);
    localparam logic signed [11:0] HIT      =
        12'(PAD_HEIGHT / 2 + BALL_SIZE / 2);

    localparam logic [9:0] CX = 10'(SCREEN_WIDTH / 2);
    localparam logic [8:0] CY = 9'(SCREEN_HEIGHT / 2);

    phase_e state_q, state_d;

    logic [8:0]    pad_l_q, pad_l_d;
    logic [8:0]    pad_r_q, pad_r_d;
    logic [9:0]    ball_x_q, ball_x_d;
    logic [8:0]    ball_y_q, ball_y_d;
    logic          dir_x_q, dir_x_d;   // 1 = moving right
    logic          dir_y_q, dir_y_d;   // 1 = moving down
    logic [3:0]    score_l_q, score_l_d;
    logic [3:0]    score_r_q, score_r_d;
    logic [PW-1:0] pause_q, pause_d;

    logic signed [11:0] bx_s, by_s, pl_s, pr_s;
    logic signed [11:0] nx, ny, dyl, dyr;
    logic               hit_l, hit_r;
    logic               miss_l, miss_r;
    logic               win;

    // Paddle step with clamping, in signed arithmetic so nothing wraps.
    function automatic logic [8:0] pad_step(
        input logic [8:0] y,
        input logic       up,
        input logic       dn
    );
        logic signed [11:0] t;
        t = signed'({3'b000, y});
        if (up && !dn) begin
            t = t - PAD_STEP;
        end else if (dn && !up) begin
            t = t + PAD_STEP;
        end
        if (t < PAD_MIN) begin
            t = PAD_MIN;
        end else if (t > PAD_MAX) begin
            t = PAD_MAX;
        end
        return t[8:0];
    endfunction

    // Candidate ball motion and paddle/miss decisions from current state.
    always_comb begin
        bx_s   = signed'({2'b00, ball_x_q});
        by_s   = signed'({3'b000, ball_y_q});
        pl_s   = signed'({3'b000, pad_l_q});
        pr_s   = signed'({3'b000, pad_r_q});
        nx     = dir_x_q ? bx_s + BSPD : bx_s - BSPD;
        ny     = dir_y_q ? by_s + BSPD : by_s - BSPD;
        dyl    = by_s - pl_s;
        dyr    = by_s - pr_s;
        hit_l  = !dir_x_q && (bx_s >= XL) && (nx < XL)
                 && (dyl < HIT) && (dyl > -HIT);
        hit_r  = dir_x_q && (bx_s <= XR) && (nx > XR)
                 && (dyr < HIT) && (dyr > -HIT);
        miss_l = (nx <= MISS_L);
        miss_r = (nx >= MISS_R);
        win    = 1'b0;
        if (miss_l) begin
            win = (5'(score_r_q) + 5'd1) == 5'(WIN_SCORE);
        end else if (miss_r) begin
            win = (5'(score_l_q) + 5'd1) == 5'(WIN_SCORE);
        end
    end

    // State register: phase and all game state.
    always_ff @(posedge clk_vga or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            pad_l_q   <= CY;
            pad_r_q   <= CY;
            ball_x_q  <= CX;
            ball_y_q  <= CY;
            dir_x_q   <= 1'b1;
            dir_y_q   <= 1'b1;
            score_l_q <= 4'd0;
            score_r_q <= 4'd0;
            pause_q   <= '0;
        end else begin
            state_q   <= state_d;
            pad_l_q   <= pad_l_d;
            pad_r_q   <= pad_r_d;
            ball_x_q  <= ball_x_d;
            ball_y_q  <= ball_y_d;
            dir_x_q   <= dir_x_d;
            dir_y_q   <= dir_y_d;
            score_l_q <= score_l_d;
            score_r_q <= score_r_d;
            pause_q   <= pause_d;
        end
    end

    // Next-phase decision, taken only on frame ticks.
    always_comb begin
        state_d = state_q;
        if (bus.frame_tick) begin
            unique case (state_q)
                IDLE: begin
                    if (bus.serve) begin
                        state_d = PLAY;
                    end
                end
                PLAY: begin
                    if (miss_l || miss_r) begin
                        state_d = win ? OVER : POINT;
                    end
                end
                POINT: begin
                    if (pause_q == PW'(1)) begin
                        state_d = IDLE;
                    end
                end
                OVER: begin
                    if (bus.serve) begin
                        state_d = IDLE;
                    end
                end
            endcase
        end
    end

    // Per-frame datapath update for paddles, ball, scores and pause timer.
    always_comb begin
        pad_l_d   = pad_l_q;
        pad_r_d   = pad_r_q;
        ball_x_d  = ball_x_q;
        ball_y_d  = ball_y_q;
        dir_x_d   = dir_x_q;
        dir_y_d   = dir_y_q;
        score_l_d = score_l_q;
        score_r_d = score_r_q;
        pause_d   = pause_q;
        if (bus.frame_tick) begin
            if (state_q != OVER) begin
                pad_l_d = pad_step(pad_l_q, bus.btn_left_up,
                                   bus.btn_left_down);
                pad_r_d = pad_step(pad_r_q, bus.btn_right_up,
                                   bus.btn_right_down);
            end
            unique case (state_q)
                IDLE: begin
                    ball_x_d = CX;
                    ball_y_d = CY;
                    if (bus.serve) begin
                        dir_y_d = ~dir_y_q;
                    end
                end
                PLAY: begin
                    if (miss_l || miss_r) begin
                        // Ball freezes; next serve heads to the loser.
                        pause_d = PW'(PAUSE_FRAMES);
                        dir_x_d = miss_r;
                        if (miss_l) begin
                            score_r_d = score_r_q + 4'd1;
                        end else begin
                            score_l_d = score_l_q + 4'd1;
                        end
                    end else begin
                        if (ny < Y_MIN) begin
                            ball_y_d = Y_MIN[8:0];
                            dir_y_d  = 1'b1;
                        end else if (ny > Y_MAX) begin
                            ball_y_d = Y_MAX[8:0];
                            dir_y_d  = 1'b0;
                        end else begin
                            ball_y_d = ny[8:0];
                        end
                        if (hit_l) begin
                            ball_x_d = XL[9:0];
                            dir_x_d  = 1'b1;
                        end else if (hit_r) begin
                            ball_x_d = XR[9:0];
                            dir_x_d  = 1'b0;
                        end else begin
                            ball_x_d = nx[9:0];
                        end
                    end
                end
                POINT: begin
                    pause_d = pause_q - PW'(1);
                    if (pause_q == PW'(1)) begin
                        ball_x_d = CX;
                        ball_y_d = CY;
                    end
                end
                OVER: begin
                    if (bus.serve) begin
                        score_l_d = 4'd0;
                        score_r_d = 4'd0;
                        ball_x_d  = CX;
                        ball_y_d  = CY;
                        pad_l_d   = CY;
                        pad_r_d   = CY;
                        dir_x_d   = 1'b1;
                    end
                end
            endcase
        end
    end

    assign bus.pad_left    = pad_l_q;
    assign bus.pad_right   = pad_r_q;
    assign bus.ball_x      = ball_x_q;
    assign bus.ball_y      = ball_y_q;
    assign bus.score_left  = score_l_q;
    assign bus.score_right = score_r_q;
    assign bus.phase       = state_q;

endmodule

// File: tb/tb_pong_game_controller.sv
// Randomised scoreboard bench for pong_game_controller.
// A frame-level game model predicts every post-tick snapshot.
module tb_pong_game_controller;

    logic clk_vga = 1'b0;
    logic rst;

    pong_if bus ();

    pong_game_controller dut (
        .clk_vga (clk_vga),
        .rst     (rst),
        .bus     (bus)
    );

    always #5 clk_vga = ~clk_vga;

    typedef struct {
        int pl;
        int pr;
        int bx;
        int by;
        int sl;
        int sr;
        int ph;
    } snap_t;

    snap_t exp_q[$];
    snap_t mon_e;
    int    checks = 0;
    int    errors = 0;

    // game model: dx/dy are +1/-1, phase 0..3
    int m_pl, m_pr, m_bx, m_by, m_dx, m_dy;
    int m_sl, m_sr, m_ph, m_cnt;
    int n_miss = 0, n_hit = 0, n_wall = 0, n_over = 0, n_rst = 0;

    function automatic int clampi(int v, int lo, int hi);
        if (v < lo) return lo;
        if (v > hi) return hi;
        return v;
    endfunction

    function automatic int absi(int v);
        return (v < 0) ? -v : v;
    endfunction

    function automatic int mv(bit u, bit d);
        if (u && !d) return -4;
        if (d && !u) return 4;
        return 0;
    endfunction

    task automatic model_reset();
        m_pl = 240; m_pr = 240; m_bx = 320; m_by = 240;
        m_dx = 1; m_dy = 1; m_sl = 0; m_sr = 0;
        m_ph = 0; m_cnt = 0;
    endtask

    task automatic model_step(input bit lu, input bit ld,
                              input bit ru, input bit rd,
                              input bit sv);
        int npl, npr, nx, ny, nby, ndy, nbx, ndx;
        npl = m_pl;
        npr = m_pr;
        if (m_ph != 3) begin
            npl = clampi(m_pl + mv(lu, ld), 32, 447);
            npr = clampi(m_pr + mv(ru, rd), 32, 447);
        end
        case (m_ph)
            0: if (sv) begin
                m_ph = 1;
                m_dy = -m_dy;
            end
            1: begin
                nx = m_bx + 2 * m_dx;
                ny = m_by + 2 * m_dy;
                if (nx <= 4 || nx >= 635) begin
                    n_miss++;
                    if (nx <= 4) begin
                        m_sr++;
                        m_dx = -1;
                    end else begin
                        m_sl++;
                        m_dx = 1;
                    end
                    m_cnt = 60;
                    m_ph = (m_sl == 9 || m_sr == 9) ? 3 : 2;
                    if (m_ph == 3) n_over++;
                end else begin
                    nby = ny; ndy = m_dy;
                    if (ny < 4) begin
                        nby = 4; ndy = 1; n_wall++;
                    end else if (ny > 475) begin
                        nby = 475; ndy = -1; n_wall++;
                    end
                    nbx = nx; ndx = m_dx;
                    if (m_dx < 0 && m_bx >= 28 && nx < 28
                        && absi(m_by - m_pl) < 36) begin
                        nbx = 28; ndx = 1; n_hit++;
                    end
                    if (m_dx > 0 && m_bx <= 612 && nx > 612
                        && absi(m_by - m_pr) < 36) begin
                        nbx = 612; ndx = -1; n_hit++;
                    end
                    m_bx = nbx; m_dx = ndx;
                    m_by = nby; m_dy = ndy;
                end
            end
            2: begin
                m_cnt--;
                if (m_cnt == 0) begin
                    m_bx = 320; m_by = 240; m_ph = 0;
                end
            end
            default: if (sv) begin
                m_sl = 0; m_sr = 0;
                m_bx = 320; m_by = 240;
                npl = 240; npr = 240;
                m_ph = 0; m_dx = 1;
            end
        endcase
        m_pl = npl;
        m_pr = npr;
    endtask

    function automatic snap_t model_snap();
        snap_t s;
        s.pl = m_pl; s.pr = m_pr; s.bx = m_bx; s.by = m_by;
        s.sl = m_sl; s.sr = m_sr; s.ph = m_ph;
        return s;
    endfunction

    function automatic snap_t dut_snap();
        snap_t s;
        s.pl = int'(bus.pad_left);
        s.pr = int'(bus.pad_right);
        s.bx = int'(bus.ball_x);
        s.by = int'(bus.ball_y);
        s.sl = int'(bus.score_left);
        s.sr = int'(bus.score_right);
        s.ph = int'(bus.phase);
        return s;
    endfunction

    task automatic compare(input string name, input snap_t a,
                           input snap_t e);
        checks++;
        if (a != e) begin
            errors++;
            $display("FAIL %s: got pl=%0d pr=%0d bx=%0d by=%0d sl=%0d sr=%0d ph=%0d want pl=%0d pr=%0d bx=%0d by=%0d sl=%0d sr=%0d ph=%0d",
                     name, a.pl, a.pr, a.bx, a.by, a.sl, a.sr, a.ph,
                     e.pl, e.pr, e.bx, e.by, e.sl, e.sr, e.ph);
        end
    endtask

    // Monitor: every tick edge the DUT presents a new snapshot.
    always begin
        @(posedge clk_vga);
        if (bus.frame_tick === 1'b1 && rst === 1'b0) begin
            #1;
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL tick: DUT updated with no expected entry");
            end else begin
                mon_e = exp_q.pop_front();
                compare("tick", dut_snap(), mon_e);
            end
        end
    end

    task automatic rand_inputs();
        bus.btn_left_up    = 1'($urandom_range(0, 1));
        bus.btn_left_down  = 1'($urandom_range(0, 1));
        bus.btn_right_up   = 1'($urandom_range(0, 1));
        bus.btn_right_down = 1'($urandom_range(0, 1));
        bus.serve          = 1'($urandom_range(0, 1));
    endtask

    task automatic do_tick(input bit lu, input bit ld,
                           input bit ru, input bit rd,
                           input bit sv);
        @(negedge clk_vga);
        bus.frame_tick     = 1'b1;
        bus.btn_left_up    = lu;
        bus.btn_left_down  = ld;
        bus.btn_right_up   = ru;
        bus.btn_right_down = rd;
        bus.serve          = sv;
        model_step(lu, ld, ru, rd, sv);
        exp_q.push_back(model_snap());
        @(negedge clk_vga);
        bus.frame_tick = 1'b0;
        rand_inputs();
        repeat ($urandom_range(0, 2)) @(negedge clk_vga);
    endtask

    task automatic check_const(input string name, input int pl,
                               input int pr, input int bx, input int by,
                               input int sl, input int sr, input int ph);
        snap_t e;
        e.pl = pl; e.pr = pr; e.bx = bx; e.by = by;
        e.sl = sl; e.sr = sr; e.ph = ph;
        compare(name, dut_snap(), e);
    endtask

    // Asynchronous reset between clock edges, checked before any edge.
    task automatic async_reset();
        @(negedge clk_vga);
        #2;
        rst = 1'b1;
        #1;
        check_const("async_reset", 240, 240, 320, 240, 0, 0, 0);
        @(negedge clk_vga);
        @(negedge clk_vga);
        rst = 1'b0;
        model_reset();
        n_rst++;
    endtask

    // Player policy: track the ball sometimes, otherwise press randomly.
    function automatic bit [1:0] player(input int pad, input int pct);
        bit [1:0] b;
        if (int'($urandom_range(0, 99)) < pct) begin
            b[1] = (pad > m_by);
            b[0] = (pad < m_by);
        end else begin
            b = 2'($urandom_range(0, 3));
        end
        return b;
    endfunction

    initial begin
        bit [1:0] l, r;
        bit       sv;
        rst = 1'b1;
        bus.frame_tick     = 1'b0;
        bus.btn_left_up    = 1'b0;
        bus.btn_left_down  = 1'b0;
        bus.btn_right_up   = 1'b0;
        bus.btn_right_down = 1'b0;
        bus.serve          = 1'b0;
        model_reset();
        repeat (3) @(negedge clk_vga);
        rst = 1'b0;
        @(negedge clk_vga);
        check_const("reset_state", 240, 240, 320, 240, 0, 0, 0);

        for (int i = 0; i < 60; i++) begin
            do_tick(1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
        end
        @(negedge clk_vga);
        check_const("pad_clamp", 32, 240, 320, 240, 0, 0, 0);

        for (int i = 0; i < 12000; i++) begin
            if (m_ph == 1 && n_rst < 3
                && $urandom_range(0, 299) == 0) begin
                async_reset();
            end
            l  = player(m_pl, 55);
            r  = player(m_pr, 40);
            sv = ($urandom_range(0, 3) == 0);
            do_tick(l[1], l[0], r[1], r[0], sv);
        end

        repeat (4) @(negedge clk_vga);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d snapshots never presented, want 0",
                     exp_q.size());
        end
        $display("info: misses=%0d hits=%0d walls=%0d overs=%0d resets=%0d",
                 n_miss, n_hit, n_wall, n_over, n_rst);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
